// File: rtl/icache_pkg.sv
// Shared types and widths for the instruction cache responder.
// Contents: FSM state enum, line/word geometry, address-field widths and a
// helper that selects one word out of a refill line.
package icache_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int unsigned PADDR_W        = 30;
  localparam int unsigned OFF_W          = 2;
  localparam int unsigned LADDR_W        = PADDR_W - OFF_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_e;

  // Word k of a line lives at bits [32k+31:32k]; no byte reordering here.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[int'(off)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// slave  : cache view (serves fetch requests, issues line refills)
// master : environment view (fetch stage plus instruction memory)
interface icache_responder_if;
  import icache_pkg::*;

  logic               proc_read;
  logic [PADDR_W-1:0] proc_addr;
  logic [WORD_W-1:0]  proc_rdata;
  logic               proc_stall;
  logic               mem_read;
  logic [LADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_ready;

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_addr
  );

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_addr
  );

endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache, built from registers.
// Ports: clk, rst_n; combinational read port (rd_idx -> rd_valid, rd_tag,
// rd_line); synchronous write port (wr_en, wr_idx, wr_tag, wr_line).
// Only the valid bits are reset; tag and data are qualified by valid.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [$clog2(NUM_BLOCKS)-1:0]       rd_idx,
  output logic                                rd_valid,
  output logic [LADDR_W-$clog2(NUM_BLOCKS)-1:0] rd_tag,
  output logic [LINE_W-1:0]                   rd_line,
  input  logic                                wr_en,
  input  logic [$clog2(NUM_BLOCKS)-1:0]       wr_idx,
  input  logic [LADDR_W-$clog2(NUM_BLOCKS)-1:0] wr_tag,
  input  logic [LINE_W-1:0]                   wr_line
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = LADDR_W - IDX_W;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [LINE_W-1:0]     data_q [NUM_BLOCKS];

  // Valid bits: cleared by reset, set by a completed refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache between fetch and instruction
// memory. Hits answer combinationally in the request cycle; a miss stalls,
// refills one 128-bit line over the mem_* handshake, then hits.
// Ports: clk, rst_n (async, active low); bus (icache_responder_if.slave):
// proc_read/proc_addr in, proc_rdata/proc_stall out (combinational),
// mem_read/mem_addr out (registered), mem_rdata/mem_ready in.
// Optional: ICACHE_PERF_EN adds hit_cnt/miss_cnt counter outputs.
module icache_responder
  import icache_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  icache_responder_if.slave  bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = LADDR_W - IDX_W;

  state_e               state_q, state_d;
  logic [LADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic                 mem_read_q;
  logic [LADDR_W-1:0]   mem_addr_q;

  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [OFF_W-1:0]     req_off;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_W-1:0]    rd_line;
  logic                 hit;

  logic                 wr_en;
  logic                 stall_c;
  logic [WORD_W-1:0]    rdata_c;
  logic                 cnt_hit;
  logic                 cnt_miss;

  assign req_off = bus.proc_addr[OFF_W-1:0];
  assign req_idx = bus.proc_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = bus.proc_addr[PADDR_W-1:OFF_W+IDX_W];

  icache_line_array #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (miss_addr_q[IDX_W-1:0]),
    .wr_tag   (miss_addr_q[LADDR_W-1:IDX_W]),
    .wr_line  (bus.mem_rdata)
  );

  assign hit = bus.proc_read & rd_valid & (rd_tag == req_tag);

  // State and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      mem_read_q  <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      mem_read_q  <= (state_d == S_MISS);
      mem_addr_q  <= (state_d == S_MISS) ? miss_addr_d : '0;
    end
  end

  // Next state, fetch-side response and refill write strobe.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    stall_c     = 1'b0;
    rdata_c     = '0;
    wr_en       = 1'b0;
    cnt_hit     = 1'b0;
    cnt_miss    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.proc_read) begin
          if (hit) begin
            rdata_c = line_word(rd_line, req_off);
            cnt_hit = 1'b1;
          end else begin
            stall_c     = 1'b1;
            miss_addr_d = bus.proc_addr[PADDR_W-1:OFF_W];
            state_d     = S_MISS;
            cnt_miss    = 1'b1;
          end
        end
      end
      S_MISS: begin
        // proc_addr is ignored here; the refill targets the latched line.
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch outputs are forced quiet while reset is asserted.
  assign bus.proc_stall = stall_c & rst_n;
  assign bus.proc_rdata = rst_n ? rdata_c : '0;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_addr   = mem_addr_q;

`ifdef ICACHE_PERF_EN
  // Hit and miss event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cnt_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (cnt_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule
